pipe_hazard_ctrl: RTL

//  Central pipeline sequencer. Owns the stall inputs of stage-A and IF/ID registers.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 19 +
 rtl/pipe_hazard_ctrl_fwd_select.sv | 25 ++
 rtl/pipe_hazard_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline sequencer: forwarding selects and sequencer states.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN,
    MULTI,
    DRAIN,
    HALTED
  } seq_state_e;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Per-operand forwarding source select; stage A beats MEM, loads in stage A never forward.
module fwd_select
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned RAW = 4
) (
  input  logic [RAW-1:0] rs,
  input  logic           ex_reg_wr,
  input  logic           ex_is_load,
  input  logic [RAW-1:0] ex_rd,
  input  logic           mem_reg_wr,
  input  logic [RAW-1:0] mem_rd,
  output fwd_sel_e       sel
);

  always_comb begin
    sel = FWD_RF;
    if (ex_reg_wr && !ex_is_load && (ex_rd == rs)) begin
      sel = FWD_EX;
    end else if (mem_reg_wr && (mem_rd == rs)) begin
      sel = FWD_MEM;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: load-use bubbles, multi-cycle hold in stage A, HALT drain,
// and operand forwarding selects.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned RAW          = 4,
  parameter int unsigned MULTI_CYCLES = 4,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           id_valid,
  input  logic [RAW-1:0] id_rs1,
  input  logic [RAW-1:0] id_rs2,
  input  logic           id_use_rs1,
  input  logic           id_use_rs2,
  input  logic           id_is_halt,
  input  logic           ex_reg_wr,
  input  logic [RAW-1:0] ex_rd,
  input  logic           ex_is_load,
  input  logic           ex_is_multi,
  input  logic           mem_reg_wr,
  input  logic [RAW-1:0] mem_rd,
  output logic           stall_fd,
  output logic           stall_a,
  output logic           bubble_a,
  output fwd_sel_e       fwd_a,
  output fwd_sel_e       fwd_b,
  output logic           halt_sys,
  output logic           busy
);

  localparam logic [CNT_W-1:0] MULTI_LOAD = CNT_W'(MULTI_CYCLES - 2);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  seq_state_e       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             halt_q;
  logic             load_use;
  logic             sfd, sa, bub;
  fwd_sel_e         sel_a, sel_b;

  assign load_use = ex_is_load && ex_reg_wr && id_valid &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sfd      = 1'b0;
    sa       = 1'b0;
    bub      = 1'b0;
    unique case (state)
      RUN: begin
        if (ex_is_multi) begin
          sfd      = 1'b1;
          sa       = 1'b1;
          cnt_nx   = MULTI_LOAD;
          state_nx = MULTI;
        end else if (load_use) begin
          sfd = 1'b1;
          bub = 1'b1;
        end else if (id_valid && id_is_halt) begin
          sfd      = 1'b1;
          bub      = 1'b1;
          cnt_nx   = DRAIN_LOAD;
          state_nx = DRAIN;
        end
      end
      MULTI: begin
        // Last MULTI cycle releases the stalls so the op leaves stage A.
        if (cnt != '0) begin
          sfd    = 1'b1;
          sa     = 1'b1;
          cnt_nx = cnt - 1'b1;
        end else begin
          state_nx = RUN;
        end
      end
      DRAIN: begin
        sfd = 1'b1;
        bub = 1'b1;
        if (cnt == '0) begin
          state_nx = HALTED;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      HALTED: begin
        sfd = 1'b1;
        sa  = 1'b1;
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      cnt    <= '0;
      halt_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      halt_q <= (state_nx == HALTED);
    end
  end

  fwd_select #(.RAW(RAW)) u_fwd_a (
    .rs         (id_rs1),
    .ex_reg_wr  (ex_reg_wr),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .mem_reg_wr (mem_reg_wr),
    .mem_rd     (mem_rd),
    .sel        (sel_a)
  );

  fwd_select #(.RAW(RAW)) u_fwd_b (
    .rs         (id_rs2),
    .ex_reg_wr  (ex_reg_wr),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .mem_reg_wr (mem_reg_wr),
    .mem_rd     (mem_rd),
    .sel        (sel_b)
  );

  // Outputs are forced low while reset is held, independent of the clock.
  assign stall_fd = sfd & ~rst;
  assign stall_a  = sa & ~rst;
  assign bubble_a = bub & ~rst;
  assign fwd_a    = rst ? FWD_RF : sel_a;
  assign fwd_b    = rst ? FWD_RF : sel_b;
  assign halt_sys = halt_q & ~rst;
  assign busy     = (state != RUN) & ~rst;

endmodule
